ysyx_23060124_mem_arbiter: RTL
==============================

// Module: ysyx_23060124_mem_arbiter
// PURPOSE
//  Shares one memory port between IFU (read-only) and LSU (load/store), replacing direct DPI pmem calls from each unit.
//  Round-robin arbitration, one outstanding transaction, request latched, response routed back to its owner as a 1-cycle pulse.
//  A response timeout returns an error instead of hanging the core.
// PARAMETERS
//  ADDR_W   32   address width
//  DATA_W   32   data width; wstrb width = DATA_W/8
//  TIMEOUT  255  max cycles waiting in RESP before error response; 0 disables timeout
// PORTS
//  clock           in   1         single clock, rising edge
//  reset           in   1         asynchronous, active-high
//  ifu_req_valid   in   1         IFU fetch request
//  ifu_req_ready   out  1         IFU request accepted this cycle
//  ifu_req_addr    in   ADDR_W    fetch address
//  ifu_resp_valid  out  1         1-cycle pulse: IFU response
//  ifu_resp_rdata  out  DATA_W    fetched word
//  ifu_resp_err    out  1         timeout error
//  lsu_req_valid   in   1         LSU request
//  lsu_req_ready   out  1         LSU request accepted this cycle
//  lsu_req_addr    in   ADDR_W    load/store address
//  lsu_req_wen     in   1         1 = store, 0 = load
//  lsu_req_wdata   in   DATA_W    store data
//  lsu_req_wstrb   in   DATA_W/8  store byte enables
//  lsu_resp_valid  out  1         1-cycle pulse: LSU response (load data or store ack)
//  lsu_resp_rdata  out  DATA_W    load data (0 for stores)
//  lsu_resp_err    out  1         timeout error
//  mem_req_valid   out  1         memory request
//  mem_req_ready   in   1         memory accepts request
//  mem_req_addr    out  ADDR_W    latched address
//  mem_req_wen     out  1         latched wen (0 for IFU)
//  mem_req_wdata   out  DATA_W    latched wdata (0 for IFU)
//  mem_req_wstrb   out  DATA_W/8  latched wstrb (0 for IFU or load)
//  mem_resp_valid  in   1         memory response
//  mem_resp_ready  out  1         arbiter accepts response
//  mem_resp_rdata  in   DATA_W    response data
// BEHAVIOUR
//  Reset (any cycle, incl. mid-transaction): state=IDLE, all outputs 0, owner=IFU, last_grant=IFU, timeout counter 0; in-flight transaction dropped, no response.
//  States: IDLE -> REQ -> RESP -> IDLE. Exactly one transaction outstanding.
//  IDLE: requester ready is combinational. Only one valid -> grant it. Both valid -> grant the one != last_grant (first tie after reset goes to LSU).
//    Grant: that *_req_ready=1 this cycle; latch addr/wen/wdata/wstrb and owner; last_grant<=owner; next state REQ. Loser's ready stays 0.
//  REQ: mem_req_valid=1 with latched fields, stable until mem_req_ready. On valid&ready -> RESP, counter<=0.
//  RESP: mem_resp_ready=1. On mem_resp_valid -> owner's *_resp_valid pulses the next cycle (registered), rdata=mem_resp_rdata, err=0; -> IDLE.
//    No valid: counter++. When counter==TIMEOUT (TIMEOUT!=0), owner's resp pulses next cycle with err=1, rdata=0; -> IDLE.
//  mem_resp_ready=0 outside RESP; memory must not respond before acceptance. A late response after timeout is not accepted.
//  Requesters hold req fields stable only until ready; the arbiter uses latched copies. *_req_ready is never asserted outside IDLE.
//  Response pulse cycle: arbiter is already in IDLE and may grant a new request in that same cycle.
//  Owner's resp_valid is high exactly 1 cycle; the non-owner's resp_valid never asserts.
//  Requester latency, minimum: grant cycle -> REQ (1) -> RESP (1) -> response pulse = 3 cycles with zero-wait memory.
// TESTING
//  IFU only, addr 0x80000000, mem ready immediately, rdata 0x00000413 -> ifu_resp_valid 1 cycle with 0x00000413, err=0; lsu_resp_valid stays 0.
//  IFU and LSU both valid after reset -> LSU granted first; IFU granted on the next IDLE; third tie -> LSU again.
//  LSU store addr 0x80001000, wdata 0xDEADBEEF, wstrb 0x3 -> mem_req fields match; mem_req_valid held while mem_req_ready is low for 5 cycles; lsu_resp_valid with rdata 0.
//  TIMEOUT=4, no mem_resp_valid -> owner resp pulse with err=1, rdata=0 after 4 cycles in RESP; a later mem_resp_valid is ignored (mem_resp_ready=0).
//  Reset asserted in RESP -> outputs 0 immediately; after release, a new IFU request completes normally.
//  Back-to-back: LSU valid in the same cycle IFU's response pulses -> LSU granted that cycle.

Source files
------------

// File: rtl/ysyx_23060124_mem_arbiter_if.sv
// Bus bundle between the IFU/LSU requesters, the shared-memory arbiter and the memory port.
// slave is the arbiter's view; master is the view of the cores plus the memory behind it.
interface ysyx_23060124_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  ifu_req_valid;
    logic                  ifu_req_ready;
    logic [ADDR_W-1:0]     ifu_req_addr;
    logic                  ifu_resp_valid;
    logic [DATA_W-1:0]     ifu_resp_rdata;
    logic                  ifu_resp_err;

    logic                  lsu_req_valid;
    logic                  lsu_req_ready;
    logic [ADDR_W-1:0]     lsu_req_addr;
    logic                  lsu_req_wen;
    logic [DATA_W-1:0]     lsu_req_wdata;
    logic [DATA_W/8-1:0]   lsu_req_wstrb;
    logic                  lsu_resp_valid;
    logic [DATA_W-1:0]     lsu_resp_rdata;
    logic                  lsu_resp_err;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_W-1:0]     mem_req_addr;
    logic                  mem_req_wen;
    logic [DATA_W-1:0]     mem_req_wdata;
    logic [DATA_W/8-1:0]   mem_req_wstrb;
    logic                  mem_resp_valid;
    logic                  mem_resp_ready;
    logic [DATA_W-1:0]     mem_resp_rdata;

    modport slave (
        input  ifu_req_valid, ifu_req_addr,
        output ifu_req_ready, ifu_resp_valid, ifu_resp_rdata, ifu_resp_err,
        input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wstrb,
        output lsu_req_ready, lsu_resp_valid, lsu_resp_rdata, lsu_resp_err,
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
        input  mem_req_ready,
        input  mem_resp_valid, mem_resp_rdata,
        output mem_resp_ready
    );

    modport master (
        output ifu_req_valid, ifu_req_addr,
        input  ifu_req_ready, ifu_resp_valid, ifu_resp_rdata, ifu_resp_err,
        output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wstrb,
        input  lsu_req_ready, lsu_resp_valid, lsu_resp_rdata, lsu_resp_err,
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
        output mem_req_ready,
        output mem_resp_valid, mem_resp_rdata,
        input  mem_resp_ready
    );
endinterface

// File: rtl/ysyx_23060124_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU and LSU, one transaction in flight.
// The timeout fires on the TIMEOUT-th consecutive RESP cycle without a memory response.
module ysyx_23060124_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    ysyx_23060124_mem_arbiter_if.slave bus
);
    localparam int STRB_W  = DATA_W / 8;
    localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;
    typedef enum logic {OWN_IFU = 1'b0, OWN_LSU = 1'b1} owner_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              wen;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } req_t;

    state_e           state, state_nxt;
    owner_e           owner, last_grant;
    req_t             req_q;
    logic [CNT_W-1:0] cnt;
    logic             grant_ifu, grant_lsu, fire, fire_err;

    logic              ifu_rv, ifu_re, lsu_rv, lsu_re;
    logic [DATA_W-1:0] ifu_rd, lsu_rd;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Grants are gated by reset so every output reads 0 while reset is held.
    always_comb begin
        state_nxt = state;
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        fire      = 1'b0;
        fire_err  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!reset) begin
                    if (bus.ifu_req_valid && bus.lsu_req_valid) begin
                        grant_lsu = (last_grant == OWN_IFU);
                        grant_ifu = (last_grant == OWN_LSU);
                    end else begin
                        grant_ifu = bus.ifu_req_valid;
                        grant_lsu = bus.lsu_req_valid;
                    end
                    if (grant_ifu || grant_lsu) state_nxt = REQ;
                end
            end
            REQ: begin
                if (bus.mem_req_ready) state_nxt = RESP;
            end
            RESP: begin
                if (bus.mem_resp_valid) begin
                    fire      = 1'b1;
                    state_nxt = IDLE;
                end else if (TIMEOUT != 0 && cnt == CNT_W'(TO_LAST)) begin
                    fire      = 1'b1;
                    fire_err  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_q      <= '0;
            owner      <= OWN_IFU;
            last_grant <= OWN_IFU;
            cnt        <= '0;
            ifu_rv     <= 1'b0;
            ifu_rd     <= '0;
            ifu_re     <= 1'b0;
            lsu_rv     <= 1'b0;
            lsu_rd     <= '0;
            lsu_re     <= 1'b0;
        end else begin
            ifu_rv <= 1'b0;
            lsu_rv <= 1'b0;
            if (grant_ifu) begin
                req_q      <= '{addr: bus.ifu_req_addr, wen: 1'b0, wdata: '0, wstrb: '0};
                owner      <= OWN_IFU;
                last_grant <= OWN_IFU;
            end else if (grant_lsu) begin
                req_q      <= '{addr:  bus.lsu_req_addr,
                                wen:   bus.lsu_req_wen,
                                wdata: bus.lsu_req_wdata,
                                wstrb: bus.lsu_req_wen ? bus.lsu_req_wstrb : '0};
                owner      <= OWN_LSU;
                last_grant <= OWN_LSU;
            end
            if (state == REQ)               cnt <= '0;
            else if (state == RESP && !fire) cnt <= cnt + 1'b1;
            if (fire) begin
                if (owner == OWN_IFU) begin
                    ifu_rv <= 1'b1;
                    ifu_rd <= fire_err ? '0 : bus.mem_resp_rdata;
                    ifu_re <= fire_err;
                end else begin
                    // store acks carry no data
                    lsu_rv <= 1'b1;
                    lsu_rd <= (fire_err || req_q.wen) ? '0 : bus.mem_resp_rdata;
                    lsu_re <= fire_err;
                end
            end
        end
    end

    assign bus.ifu_req_ready  = grant_ifu;
    assign bus.lsu_req_ready  = grant_lsu;
    assign bus.mem_req_valid  = (state == REQ);
    assign bus.mem_req_addr   = req_q.addr;
    assign bus.mem_req_wen    = req_q.wen;
    assign bus.mem_req_wdata  = req_q.wdata;
    assign bus.mem_req_wstrb  = req_q.wstrb;
    assign bus.mem_resp_ready = (state == RESP);
    assign bus.ifu_resp_valid = ifu_rv;
    assign bus.ifu_resp_rdata = ifu_rd;
    assign bus.ifu_resp_err   = ifu_re;
    assign bus.lsu_resp_valid = lsu_rv;
    assign bus.lsu_resp_rdata = lsu_rd;
    assign bus.lsu_resp_err   = lsu_re;
endmodule
